div_seq: RTL and testbench

- Sequential unsigned restoring divider: the inverse of the 1-bit multiplier cell array used by the multiplier datapath.
- Computes dividend / divisor one quotient bit per clock, MSB first, using an N-bit subtract/restore step.
- Sits beside the array multiplier in the arithmetic datapath.
- Driven by a start pulse; returns quotient and remainder with a one-cycle done pulse.

---
 rtl/div_seq.sv | 131 +++++++++++++
 tb/tb_div_seq.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/div_seq.sv
// Sequential unsigned restoring divider.
// Produces one quotient bit per clock, MSB first, with a one-cycle done pulse.
module div_seq #(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div0
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  rem_q, rem_d;
    logic [N-1:0]  shq_q, shq_d;
    logic [N-1:0]  dsr_q, dsr_d;
    logic          zero_q, zero_d;
    logic [N-1:0]  quo_q, quo_d;
    logic [N-1:0]  rmd_q, rmd_d;
    logic          div0_q, div0_d;

    logic [N:0]    trial;
    logic [N:0]    diff;
    logic [N-1:0]  step_rem;
    logic [N-1:0]  step_q;

    // Partial remainder stays below the divisor, so the top bit of the
    // (N+1)-bit difference is exactly the "trial < divisor" borrow.
    always_comb begin
        trial    = {rem_q, shq_q[N-1]};
        diff     = trial - {1'b0, dsr_q};
        step_rem = diff[N] ? trial[N-1:0] : diff[N-1:0];
        step_q   = {shq_q[N-2:0], ~diff[N]};
    end

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        rem_d   = rem_q;
        shq_d   = shq_q;
        dsr_d   = dsr_q;
        zero_d  = zero_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        div0_d  = div0_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    dsr_d   = divisor;
                    shq_d   = dividend;
                    rem_d   = '0;
                    zero_d  = (divisor == '0);
                    count_d = (divisor == '0) ? '0 : CW'(N - 1);
                    state_d = CALC;
                end
            end
            CALC: begin
                // A zero divisor spends one cycle here so its done follows the first edge.
                if (zero_q) begin
                    quo_d   = '1;
                    rmd_d   = shq_q;
                    div0_d  = 1'b1;
                    state_d = DONE;
                end else begin
                    rem_d = step_rem;
                    shq_d = step_q;
                    if (count_q == '0) begin
                        quo_d   = step_q;
                        rmd_d   = step_rem;
                        div0_d  = 1'b0;
                        state_d = DONE;
                    end else begin
                        count_d = count_q - CW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
            rem_q   <= '0;
            shq_q   <= '0;
            dsr_q   <= '0;
            zero_q  <= 1'b0;
            quo_q   <= '0;
            rmd_q   <= '0;
            div0_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rem_q   <= rem_d;
            shq_q   <= shq_d;
            dsr_q   <= dsr_d;
            zero_q  <= zero_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            div0_q  <= div0_d;
        end
    end

    assign busy      = (state_q != IDLE);
    assign done      = (state_q == DONE);
    assign quotient  = quo_q;
    assign remainder = rmd_q;
    assign div0      = div0_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: a cycle-level arithmetic model compared
// every cycle, plus directed operations with hand-computed results.
module tb_div_seq;

    localparam int N     = 8;
    localparam int BOUND = 2 * N + 6;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [N-1:0] dividend = '0;
    logic [N-1:0] divisor = '0;
    logic         busy;
    logic         done;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div0;

    int checkCount = 0;
    int passCount  = 0;
    int doneCount  = 0;

    bit           expBusy = 1'b0;
    bit           expDone = 1'b0;
    bit           expDiv0 = 1'b0;
    logic [N-1:0] expQ = '0;
    logic [N-1:0] expR = '0;
    logic [N-1:0] pendQ = '0;
    logic [N-1:0] pendR = '0;
    bit           pendZ = 1'b0;
    logic [N-1:0] opA = '0;
    logic [N-1:0] opB = '0;
    int           remaining = 0;

    div_seq #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .dividend  (dividend),
        .divisor   (divisor),
        .busy      (busy),
        .done      (done),
        .quotient  (quotient),
        .remainder (remainder),
        .div0      (div0)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checkCount++;
        if (actual == expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, actual, expected, $time);
        end
    endtask

    // Model: an accepted op completes after N edges (1 for a zero divisor),
    // shows its result for one cycle, then the divider is idle again.
    initial begin
        longint lhs;
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                expBusy   = 1'b0;
                expDone   = 1'b0;
                expDiv0   = 1'b0;
                expQ      = '0;
                expR      = '0;
                remaining = 0;
            end else if (expDone) begin
                expDone = 1'b0;
                expBusy = 1'b0;
            end else if (expBusy) begin
                remaining--;
                if (remaining == 0) begin
                    expDone = 1'b1;
                    expQ    = pendQ;
                    expR    = pendR;
                    expDiv0 = pendZ;
                end
            end else if (start) begin
                opA     = dividend;
                opB     = divisor;
                expBusy = 1'b1;
                if (divisor == '0) begin
                    pendQ     = '1;
                    pendR     = dividend;
                    pendZ     = 1'b1;
                    remaining = 1;
                end else begin
                    pendQ     = dividend / divisor;
                    pendR     = dividend % divisor;
                    pendZ     = 1'b0;
                    remaining = N;
                end
            end
            #1;
            checkOutput("busy", busy, expBusy);
            checkOutput("done", done, expDone);
            checkOutput("quotient", quotient, expQ);
            checkOutput("remainder", remainder, expR);
            checkOutput("div0", div0, expDiv0);
            if (done) doneCount++;
            if (expDone && !expDiv0) begin
                lhs = longint'(quotient) * longint'(opB) + longint'(remainder);
                checkOutput("invariant", lhs, longint'(opA));
                checkOutput("rem_lt_div", longint'(remainder < opB), 1);
            end
        end
    end

    task automatic applyStimulus(input logic [N-1:0] a, input logic [N-1:0] b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic waitDone(output int cycles);
        cycles = 0;
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!done && cycles < BOUND);
    endtask

    task automatic runOp(input logic [N-1:0] a, input logic [N-1:0] b, input bit lit,
                         input int litQ, input int litR, input int litZ);
        int cyc;
        applyStimulus(a, b);
        waitDone(cyc);
        checkOutput("latency", cyc, (b == '0) ? 1 : N);
        if (lit) begin
            checkOutput("lit_quotient", quotient, litQ);
            checkOutput("lit_remainder", remainder, litR);
            checkOutput("lit_div0", div0, litZ);
        end
        @(posedge clk);
        #1;
    endtask

    function automatic logic [N-1:0] pickVal();
        case ($urandom_range(0, 7))
            0: return '0;
            1: return N'(1);
            2: return '1;
            3: return N'(2);
            default: return N'($urandom);
        endcase
    endfunction

    initial begin
        int cyc;
        int d0;
        repeat (3) @(posedge clk);
        #2;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_quotient", quotient, 0);
        @(negedge clk);
        rst_n = 1'b1;

        runOp(8'd100, 8'd7, 1'b1, 14, 2, 0);
        runOp(8'd255, 8'd1, 1'b1, 255, 0, 0);
        runOp(8'd5, 8'd10, 1'b1, 0, 5, 0);
        runOp(8'd255, 8'd255, 1'b1, 1, 0, 0);
        runOp(8'd37, 8'd0, 1'b1, 255, 37, 1);
        runOp(8'd9, 8'd3, 1'b1, 3, 0, 0);

        // start held high across a whole operation and the idle gap after it
        @(negedge clk);
        dividend = 8'd200;
        divisor  = 8'd9;
        start    = 1'b1;
        @(posedge clk);
        #1;
        dividend = 8'd50;
        divisor  = 8'd5;
        d0 = doneCount;
        fork
            begin
                repeat (12) @(posedge clk);
                #1;
                start = 1'b0;
            end
        join_none
        waitDone(cyc);
        checkOutput("hold_latency", cyc, N);
        checkOutput("hold_q1", quotient, 22);
        checkOutput("hold_r1", remainder, 2);
        waitDone(cyc);
        checkOutput("hold_period", cyc, N + 2);
        checkOutput("hold_q2", quotient, 10);
        checkOutput("hold_r2", remainder, 0);
        repeat (16) @(posedge clk);
        #1;
        checkOutput("hold_done_pulses", doneCount - d0, 2);

        applyStimulus(8'd100, 8'd7);
        repeat (4) @(posedge clk);
        d0 = doneCount;
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        checkOutput("abort_busy", busy, 0);
        checkOutput("abort_done", done, 0);
        checkOutput("abort_quotient", quotient, 0);
        checkOutput("abort_remainder", remainder, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(posedge clk);
        #1;
        checkOutput("abort_no_done", doneCount - d0, 0);
        runOp(8'd100, 8'd7, 1'b1, 14, 2, 0);

        for (int i = 0; i < 2000; i++) begin
            runOp(pickVal(), pickVal(), 1'b0, 0, 0, 0);
        end

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
